// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator with pixel request and test
//               pattern overlay. Produces registered h_sync/v_sync/de/
//               frame_start, issues data_req/req_x/req_y REQ_LEAD clocks
//               ahead of display enable, and drives colour outputs from
//               external data or a built-in pattern latched per frame.
// Ports       : sys_clk      pixel clock (rising edge)
//               rst          asynchronous active-high reset
//               en           timing enable
//               pattern_sel  00 data, 01 bars, 10 white, 11 checkerboard
//               data_req     pixel request, req_x/req_y its coordinates
//               data         pixel {R,G,B}, REQ_LEAD clocks after data_req
//               h_sync, v_sync, de, frame_start, red, green, blue
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int   H_SYNC   = 128,
    parameter int   H_BACK   = 88,
    parameter int   H_ACTIVE = 800,
    parameter int   H_FRONT  = 40,
    parameter int   V_SYNC   = 4,
    parameter int   V_BACK   = 23,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FRONT  = 1,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   REQ_LEAD = 1,
    parameter int   R_W      = 5,
    parameter int   G_W      = 6,
    parameter int   B_W      = 5
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [1:0]                  pattern_sel,
    output logic                        data_req,
    output logic [$clog2(H_ACTIVE)-1:0] req_x,
    output logic [$clog2(V_ACTIVE)-1:0] req_y,
    input  logic [R_W+G_W+B_W-1:0]      data,
    output logic                        h_sync,
    output logic                        v_sync,
    output logic                        de,
    output logic                        frame_start,
    output logic [R_W-1:0]              red,
    output logic [G_W-1:0]              green,
    output logic [B_W-1:0]              blue
);

    localparam int c_H_TOTAL     = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int c_V_TOTAL     = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int c_HW          = $clog2(c_H_TOTAL);
    localparam int c_VW          = $clog2(c_V_TOTAL);
    localparam int c_XW          = $clog2(H_ACTIVE);
    localparam int c_YW          = $clog2(V_ACTIVE);
    localparam int c_H_ACT_START = H_SYNC + H_BACK;
    localparam int c_V_ACT_START = V_SYNC + V_BACK;

    localparam logic [c_HW-1:0] c_H_MAX = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_MAX = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_ONE = c_HW'(1);
    localparam logic [c_VW-1:0] c_V_ONE = c_VW'(1);

    logic [c_HW-1:0] r_h_cnt;
    logic [c_VW-1:0] r_v_cnt;
    logic            r_h_sync;
    logic            r_v_sync;
    logic            r_de;
    logic            r_frame_start;
    logic            r_data_req;
    logic [c_XW-1:0] r_req_x;
    logic [c_YW-1:0] r_req_y;
    logic [1:0]      r_pat;
    logic [2:0]      r_bar;
    logic            r_chk;

    int         w_h;
    int         w_v;
    int         w_hx;
    int         w_hr;
    int         w_vy;
    logic       w_h_act;
    logic       w_h_req;
    logic       w_v_act;
    logic       w_req;
    logic       w_fs_cond;
    logic [2:0] w_bar;
    logic       w_chk;

    logic [R_W-1:0] w_red;
    logic [G_W-1:0] w_green;
    logic [B_W-1:0] w_blue;

    // ------------------------------------------------------------------
    // Raster counters; en=0 parks them at the origin so an en rise always
    // begins a fresh frame.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!en) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_H_MAX) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_V_MAX) ? '0 : r_v_cnt + c_V_ONE;
        end else begin
            r_h_cnt <= r_h_cnt + c_H_ONE;
        end
    end

    // Position decode done in 32-bit signed arithmetic so offsets past the
    // counter range (h + REQ_LEAD) and negative offsets never wrap.
    assign w_h       = int'(r_h_cnt);
    assign w_v       = int'(r_v_cnt);
    assign w_hx      = w_h - c_H_ACT_START;
    assign w_hr      = w_h + REQ_LEAD - c_H_ACT_START;
    assign w_vy      = w_v - c_V_ACT_START;
    assign w_h_act   = (w_hx >= 0) && (w_hx < H_ACTIVE);
    // Lookahead window stays within the current line because
    // REQ_LEAD <= H_SYNC + H_BACK.
    assign w_h_req   = (w_hr >= 0) && (w_hr < H_ACTIVE);
    assign w_v_act   = (w_vy >= 0) && (w_vy < V_ACTIVE);
    assign w_req     = en && w_h_req && w_v_act;
    assign w_fs_cond = en && (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_bar     = 3'((w_hx * 8) / H_ACTIVE);
    assign w_chk     = w_hx[3] ^ w_vy[3];

    // ------------------------------------------------------------------
    // Registered timing outputs, one clock behind the counter state.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_h_sync      <= ~HS_POL;
            r_v_sync      <= ~VS_POL;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
            r_data_req    <= 1'b0;
            r_req_x       <= '0;
            r_req_y       <= '0;
            r_pat         <= 2'b00;
            r_bar         <= 3'd0;
            r_chk         <= 1'b0;
        end else begin
            r_h_sync      <= (en && (w_h < H_SYNC)) ? HS_POL : ~HS_POL;
            r_v_sync      <= (en && (w_v < V_SYNC)) ? VS_POL : ~VS_POL;
            r_de          <= en && w_h_act && w_v_act;
            r_frame_start <= w_fs_cond;
            r_data_req    <= w_req;
            // Coordinates hold between requests.
            if (w_req) begin
                r_req_x <= c_XW'(w_hr);
                r_req_y <= c_YW'(w_vy);
            end
            // Pattern is sampled only at the frame origin so a frame never
            // mixes two patterns.
            if (w_fs_cond) begin
                r_pat <= pattern_sel;
            end
            r_bar <= w_bar;
            r_chk <= w_chk;
        end
    end

    // ------------------------------------------------------------------
    // Colour mux. External data arrives in the same cycle as de, so it is
    // passed through combinationally; everything else is registered.
    // ------------------------------------------------------------------
    always_comb begin
        w_red   = '0;
        w_green = '0;
        w_blue  = '0;
        if (r_de) begin
            case (r_pat)
                2'b00: {w_red, w_green, w_blue} = data;
                2'b01: begin
                    // Bar order white..black is the binary count of the
                    // index with each of G, R, B inverted.
                    w_red   = {R_W{~r_bar[1]}};
                    w_green = {G_W{~r_bar[2]}};
                    w_blue  = {B_W{~r_bar[0]}};
                end
                2'b10: begin
                    w_red   = '1;
                    w_green = '1;
                    w_blue  = '1;
                end
                default: begin
                    if (!r_chk) begin
                        w_red   = '1;
                        w_green = '1;
                        w_blue  = '1;
                    end
                end
            endcase
        end
    end

    assign h_sync      = r_h_sync;
    assign v_sync      = r_v_sync;
    assign de          = r_de;
    assign frame_start = r_frame_start;
    assign data_req    = r_data_req;
    assign req_x       = r_req_x;
    assign req_y       = r_req_y;
    assign red         = w_red;
    assign green       = w_green;
    assign blue        = w_blue;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_SYNC, default 128, meaning horizontal sync width in clocks.
REQ-002 SHALL have parameters H_BACK, H_ACTIVE and H_FRONT, defaults 88, 800 and 40, meaning horizontal back porch, active width and front porch.
REQ-003 SHALL have parameters V_SYNC, V_BACK, V_ACTIVE and V_FRONT, defaults 4, 23, 600 and 1, meaning the vertical equivalents in lines.
REQ-004 SHALL have parameters HS_POL and VS_POL, default 0, meaning sync active level (0 = active-low).
REQ-005 SHALL have parameter REQ_LEAD, default 1, range 1..H_SYNC+H_BACK, meaning clocks from data_req to pixel consumption.
REQ-006 SHALL have parameters R_W, G_W and B_W, defaults 5, 6 and 5; the data width is DW = R_W+G_W+B_W, packed {R,G,B} with MSB first.
REQ-007 sys_clk  in  1  pixel clock; all logic SHALL be on its rising edge.
REQ-008 rst  in  1  one clock; reset is asynchronous and active-high.
REQ-009 en  in  1  timing enable.
REQ-010 pattern_sel  in  2  00 external data, 01 colour bars, 10 solid white, 11 checkerboard.
REQ-011 data_req  out  1  pixel request to the frame source.
REQ-012 req_x  out  clog2(H_ACTIVE)  column being requested; req_y  out  clog2(V_ACTIVE)  row being requested; both valid while data_req=1.
REQ-013 data  in  DW  pixel, valid exactly REQ_LEAD clocks after the matching data_req.
REQ-014 h_sync, v_sync, de, frame_start  out  1 each; red, green and blue  out  R_W, G_W and B_W.

Function
REQ-015 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = the sum of the four H parameters) and wrap to 0.
REQ-016 v_cnt SHALL increment on h_cnt wrap, count 0..V_TOTAL-1, and wrap to 0 when both counters are at their maximum simultaneously.
REQ-017 Counter widths SHALL be clog2 of the totals, with no overflow at any legal parameter set.
REQ-018 Sync regions SHALL be h_cnt<H_SYNC and v_cnt<V_SYNC.
REQ-019 The active region SHALL be H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE, and likewise vertically.
REQ-020 h_sync, v_sync, de and frame_start SHALL be registered and SHALL reflect the counter state of the previous clock.
REQ-021 Sync outputs SHALL equal HS_POL/VS_POL inside the sync region and the inverse elsewhere.
REQ-022 frame_start SHALL be a one-clock pulse for h_cnt=0, v_cnt=0.
REQ-023 data_req SHALL be registered, SHALL equal de delayed backwards by REQ_LEAD clocks (data_req(t) = de(t+REQ_LEAD)), and SHALL never cross a line boundary.
REQ-024 req_x and req_y SHALL start at 0 on the first request of each line and frame, increment per request, and hold their value when data_req=0.
REQ-025 Colour outputs SHALL be 0 whenever de=0.
REQ-026 With de=1 and pattern_sel=00, colour outputs SHALL show data.
REQ-027 With de=1 and pattern_sel=01, the screen SHALL show 8 equal-width vertical bars (bar index = x*8/H_ACTIVE) in order white, yellow, cyan, green, magenta, red, blue, black, each channel all-ones or zero.
REQ-028 With de=1 and pattern_sel=10, all colour bits SHALL be 1.
REQ-029 With de=1 and pattern_sel=11, the screen SHALL show a checkerboard of 8x8 cells, white when x[3]^y[3]=0 and black otherwise.
REQ-030 pattern_sel changes SHALL take effect at the next frame_start and never mid-frame.
REQ-031 With en=0, counters SHALL be held at 0, sync outputs SHALL be inactive, de/data_req/frame_start SHALL be 0, and colour outputs SHALL be 0.
REQ-032 An en rise SHALL start a fresh frame from h_cnt=v_cnt=0, with frame_start one clock later.
REQ-033 An en fall mid-frame SHALL abort the frame, with all outputs idle on the next clock.

Reset
REQ-034 While rst=1 (asynchronous), counters and req_x/req_y SHALL be 0, the latched pattern SHALL be 00, sync outputs SHALL be inactive, and de, data_req, frame_start and colour outputs SHALL be 0.
REQ-035 A reset asserted mid-line SHALL take effect immediately, with no partial pulse completed.
REQ-036 Timing SHALL restart at h_cnt=0 on the first clock after rst release with en=1.

Verification
Bench parameters: H 2/2/8/2 (H_TOTAL 14); V 1/1/4/1 (V_TOTAL 7); REQ_LEAD=2; cycle 0 is the first clock with h_cnt=0.
REQ-037 Reset release with en=1 -> h_sync=0 on cycles 1-2 and every 14 cycles after; v_sync=0 on cycles 1-14; frame_start on cycle 1 and cycle 99.
REQ-038 Line with v_cnt=2 -> de=1 on line cycles 5-12; data_req=1 on line cycles 3-10; req_x=0..7; req_y=0.
REQ-039 pattern_sel=00 with data=DW'hF81F on every clock -> red=31, green=0, blue=31 only while de=1.
REQ-040 pattern_sel=01 written mid-frame -> output unchanged until the next frame_start; then bars of 1 pixel each, starting white (all ones).
REQ-041 en dropped at h_cnt=6 on v_cnt=3 -> next clock all outputs idle; en re-raised -> frame_start 1 clock later and req_y restarts at 0.
REQ-042 rst pulsed asynchronously mid-active -> outputs reach reset values without a clock edge; HS_POL=1 build -> h_sync high only during sync.
